// File: rtl/ps2_rx_ctrl_if.sv
// Downstream read-side bundle of the PS/2 receive controller.
// master: the controller (drives scan-code FIFO head and status).
// slave:  the consumer (LED, seven-segment or CPU MMIO) that pops and clears errors.
interface ps2_rx_ctrl_if;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       parity_err;
    logic [7:0] frame_cnt;

    modport master (
        input  rd_en,
        input  clr_err,
        output data,
        output valid,
        output overflow,
        output parity_err,
        output frame_cnt
    );

    modport slave (
        output rd_en,
        output clr_err,
        input  data,
        input  valid,
        input  overflow,
        input  parity_err,
        input  frame_cnt
    );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: synchronises the raw PS/2 pins, deframes
// 11-bit frames into scan codes and queues accepted bytes in a small FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN enables odd-parity checking;
// when undefined the parity bit is consumed but ignored and parity_err is 0.
module ps2_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_rx_ctrl_if.master     bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [2:0]    sync_q;
    logic [1:0]    dsync_q;
    logic          fe;
    logic          din;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          push_req;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
    logic          perr_evt;
    logic          perr_q;
`endif

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    frame_cnt_q;
    logic          ovf_q;
    logic          empty, full, pop, push, ovf_evt;

    // Pin synchronisers; idle-high reset so no false edge comes out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 3'b111;
            dsync_q <= 2'b11;
        end else begin
            sync_q  <= {sync_q[1:0], ps2_clk};
            dsync_q <= {dsync_q[0], ps2_data};
        end
    end

    assign fe  = sync_q[2] & ~sync_q[1];
    assign din = dsync_q[1];

    // Deframer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    // Deframer next-state: one step per PS/2 falling edge, abandon on timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = (state_q == StIdle || fe) ? '0 : to_cnt_q + 1'b1;
        push_req  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
        perr_evt  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // A high start bit is a glitch; stay put.
                if (fe && !din) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (fe) begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (fe) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = din;
`endif
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fe) begin
                    state_d = StIdle;
                    // Bad stop bit drops the frame without raising a flag.
                    if (din) begin
`ifdef PS2_PARITY_CHECK_EN
                        if (^{shift_q, par_q}) push_req = 1'b1;
                        else                   perr_evt = 1'b1;
`else
                        push_req = 1'b1;
`endif
                    end
                end
            end
        endcase
        if (state_q != StIdle && !fe && to_cnt_q == TO_MAX) begin
            state_d = StIdle;
        end
    end

    // Extra pointer MSB tells full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = bus.rd_en & ~empty;
    assign push    = push_req & (~full | pop);
    assign ovf_evt = push_req & full & ~pop;

    // FIFO pointers, frame counter and sticky flags; a new error beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            ovf_q <= ovf_evt | (ovf_q & ~bus.clr_err);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

`ifdef PS2_PARITY_CHECK_EN
    // Sticky parity error flag.
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_evt | (perr_q & ~bus.clr_err);
    end
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.valid     = ~empty;
    assign bus.data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.overflow  = ovf_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule
